// File: rtl/fir_avg_decim_u.sv
// Averaging stage after the 4-tap unsigned FIR: rounds sum/4 half-up, drops
// warm-up samples, decimates by decim_n+1 and queues results in a small FIFO.
module fir_avg_decim_u #(
    parameter int w     = 16,
    parameter int DEPTH = 4,
    parameter int WARM  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [w+1:0]             s_in,
    input  logic                     s_valid,
    input  logic [3:0]               decim_n,
    output logic [w-1:0]             avg_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int WW = (WARM > 0) ? $clog2(WARM + 1) : 1;
    localparam logic [WW-1:0] WARM_L  = WW'(WARM);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [WW-1:0]  warm_q,   warm_d;
    logic [3:0]     dcnt_q,   dcnt_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q,  level_d;
    logic           ovf_q,    ovf_d;
    logic [w-1:0]   mem_q [DEPTH];

    logic [w+2:0]   sum_rnd_s;
    logic [w-1:0]   avg_s;
    logic           in_warm_s;
    logic           push_req_s;
    logic           push_ok_s;
    logic           pop_s;
    logic           full_s;
    logic           empty_s;

    // One extra bit keeps the +2 rounding bias from wrapping at full scale.
    assign sum_rnd_s = {1'b0, s_in} + (w+3)'(2);
    assign avg_s     = w'(sum_rnd_s >> 2);

    assign in_warm_s = (warm_q < WARM_L);
    assign full_s    = (level_q == DEPTH_L);
    assign empty_s   = (level_q == LW'(0));
    assign pop_s     = out_ready && !empty_s;

    // Warm-up, decimation and FIFO bookkeeping for the coming edge.
    always_comb begin
        warm_d     = warm_q;
        dcnt_d     = dcnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;
        push_req_s = 1'b0;
        push_ok_s  = 1'b0;

        if (s_valid) begin
            if (in_warm_s) begin
                warm_d = warm_q + WW'(1);
            end else if (dcnt_q >= decim_n) begin
                // >= lets a lowered decim_n take effect without a wrap-around lockup.
                dcnt_d     = 4'd0;
                push_req_s = 1'b1;
            end else begin
                dcnt_d = dcnt_q + 4'd1;
            end
        end else begin
            warm_d = warm_q;
        end

        if (push_req_s) begin
            if (!full_s || pop_s) begin
                push_ok_s = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else begin
            push_ok_s = 1'b0;
        end

        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_ok_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state registers; reset wins over any push or pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_q   <= '0;
            dcnt_q   <= 4'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            warm_q   <= warm_d;
            dcnt_q   <= dcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= avg_s;
        end
    end

    assign avg_out   = mem_q[rd_ptr_q];
    assign out_valid = !empty_s;
    assign level     = level_q;
    assign ovf       = ovf_q;

endmodule
